// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out whitened 4-bit random values to N_REQ consumers.
// Three-state grant cycle (IDLE -> GRANT -> COOL) with optional source-freshness gating.
module rand_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter logic [7:0]  SEED          = 8'hB8,
  parameter bit          REQUIRE_FRESH = 1'b0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [3:0]       rand_src,
  input  logic             src_tick,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       rand_out,
  output logic             busy,
  output logic [7:0]       stale_cnt
);

  localparam int unsigned LW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [LW-1:0] LAST_INIT = LW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       rand_q, rand_d;
  logic             busy_q, busy_d;
  logic [7:0]       stale_q, stale_d;
  logic             fresh_q, fresh_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [LW-1:0]    last_q, last_d;

  logic             found;
  logic [LW-1:0]    win;
  logic [LW-1:0]    idx;
  logic             go;

  // Search starts one past the previous winner and wraps modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = LW'((32'(last_q) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign go = found && (!REQUIRE_FRESH || fresh_q);

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    rand_d  = rand_q;
    stale_d = stale_q;
    fresh_d = fresh_q | src_tick;
    last_d  = last_q;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d    = GRANT;
          gnt_d[win] = 1'b1;
          rand_d     = rand_src ^ lfsr_q[3:0];
          // A tick landing on the grant edge keeps the source marked fresh.
          fresh_d    = src_tick;
          last_d     = win;
          if (!fresh_q && (stale_q != 8'hFF)) stale_d = stale_q + 8'd1;
        end
      end
      GRANT:   state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rand_q  <= '0;
      busy_q  <= 1'b0;
      stale_q <= '0;
      fresh_q <= 1'b0;
      lfsr_q  <= LFSR_INIT;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rand_q  <= rand_d;
      busy_q  <= busy_d;
      stale_q <= stale_d;
      fresh_q <= fresh_d;
      lfsr_q  <= lfsr_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign rand_out  = rand_q;
  assign busy      = busy_q;
  assign stale_cnt = stale_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed bench for rand_arbiter: one instance without and one with freshness gating.
module tb_rand_arbiter;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rand_src0 = '0, rand_src1 = '0;
  logic       tick0 = 1'b0, tick1 = 1'b0;
  logic [3:0] req0 = '0, req1 = '0;
  logic [3:0] gnt0, gnt1;
  logic [3:0] rout0, rout1;
  logic       busy0, busy1;
  logic [7:0] stale0, stale1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rand_arbiter #(.N_REQ(4), .SEED(8'hB8), .REQUIRE_FRESH(1'b0)) u_dut0 (
    .CLK(CLK), .reset(reset), .rand_src(rand_src0), .src_tick(tick0), .req(req0),
    .gnt(gnt0), .rand_out(rout0), .busy(busy0), .stale_cnt(stale0)
  );

  rand_arbiter #(.N_REQ(4), .SEED(8'hB8), .REQUIRE_FRESH(1'b1)) u_dut1 (
    .CLK(CLK), .reset(reset), .rand_src(rand_src1), .src_tick(tick1), .req(req1),
    .gnt(gnt1), .rand_out(rout1), .busy(busy1), .stale_cnt(stale1)
  );

  // Reference LFSR; m_prev holds the value seen before the most recent edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 8'hB8;
      m_prev <= 8'hB8;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] src;
    logic [3:0] exp_gnt;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[15];
  int   ngr;

  initial begin
    // All-requests-high rotation after reset: grants 0,1,2,3,0 three cycles apart.
    for (int i = 0; i < 15; i++) begin
      vecs[i].req      = 4'b1111;
      vecs[i].src      = 4'(i);
      vecs[i].exp_gnt  = '0;
      vecs[i].exp_busy = ((i % 3) != 2);
    end
    vecs[0].exp_gnt  = 4'b0001;
    vecs[3].exp_gnt  = 4'b0010;
    vecs[6].exp_gnt  = 4'b0100;
    vecs[9].exp_gnt  = 4'b1000;
    vecs[12].exp_gnt = 4'b0001;

    #2;
    check("rst_gnt", 32'(gnt0), 32'h0);
    check("rst_rand", 32'(rout0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_stale", 32'(stale0), 32'h0);

    // First grant: lfsr still at seed, so whitening nibble is 8.
    #10;
    reset     = 1'b1;
    req0      = 4'b0001;
    rand_src0 = 4'h5;
    step();
    check("first_gnt", 32'(gnt0), 32'h1);
    check("first_rand_const", 32'(rout0), 32'(4'h5 ^ 4'h8));
    check("first_rand_model", 32'(rout0), 32'(4'h5 ^ m_prev[3:0]));
    check("first_busy", 32'(busy0), 32'h1);
    check("first_stale", 32'(stale0), 32'h1);
    req0 = 4'b0000;
    step();
    check("first_gnt_drop", 32'(gnt0), 32'h0);
    check("first_rand_hold", 32'(rout0), 32'h0D);
    check("cool_busy", 32'(busy0), 32'h1);
    step();
    check("idle_busy", 32'(busy0), 32'h0);

    // Next winner after req[0] is req[1]; pull reset while it is granted.
    req0 = 4'b1111;
    step();
    check("rr_second_gnt", 32'(gnt0), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt0), 32'h0);
    check("async_rst_busy", 32'(busy0), 32'h0);
    #2;
    reset = 1'b1;
    check("post_rst_rand", 32'(rout0), 32'h0);
    check("post_rst_stale", 32'(stale0), 32'h0);
    check("post_rst_gnt", 32'(gnt0), 32'h0);

    for (int i = 0; i < 15; i++) begin
      req0      = vecs[i].req;
      rand_src0 = vecs[i].src;
      step();
      check($sformatf("rot_gnt[%0d]", i), 32'(gnt0), 32'(vecs[i].exp_gnt));
      check($sformatf("rot_busy[%0d]", i), 32'(busy0), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_gnt != 4'b0000)
        check($sformatf("rot_rand[%0d]", i), 32'(rout0), 32'(vecs[i].src ^ m_prev[3:0]));
    end
    req0 = 4'b0000;
    check("rot_stale", 32'(stale0), 32'd5);

    // Stale counter saturation over 300 further grants.
    req0 = 4'b0001;
    ngr  = 0;
    for (int c = 0; c < 1200 && ngr < 300; c++) begin
      step();
      if (gnt0 == 4'b0001) ngr++;
    end
    req0 = 4'b0000;
    check("sat_grants", 32'(ngr), 32'd300);
    check("sat_stale", 32'(stale0), 32'd255);
    step();
    step();
    check("sat_idle", 32'(busy0), 32'h0);

    // Freshness gating: request parks in IDLE until a tick arrives.
    req1      = 4'b0100;
    rand_src1 = 4'hA;
    for (int c = 0; c < 50; c++) begin
      step();
      check($sformatf("wait_gnt[%0d]", c), 32'(gnt1), 32'h0);
      check($sformatf("wait_busy[%0d]", c), 32'(busy1), 32'h0);
    end
    tick1 = 1'b1;
    step();
    tick1 = 1'b0;
    check("tick_edge_gnt", 32'(gnt1), 32'h0);
    step();
    check("fresh_gnt", 32'(gnt1), 32'h4);
    check("fresh_rand", 32'(rout1), 32'(4'hA ^ m_prev[3:0]));
    check("fresh_stale", 32'(stale1), 32'h0);
    req1 = 4'b0000;
    step();
    step();
    check("fresh_idle", 32'(busy1), 32'h0);

    // Tick coinciding with the grant edge leaves fresh set for the next request.
    tick1 = 1'b1;
    step();
    req1      = 4'b0001;
    rand_src1 = 4'h3;
    step();
    tick1 = 1'b0;
    req1  = 4'b0000;
    check("coinc_gnt", 32'(gnt1), 32'h1);
    check("coinc_rand", 32'(rout1), 32'(4'h3 ^ m_prev[3:0]));
    check("coinc_stale", 32'(stale1), 32'h0);
    step();
    step();
    req1 = 4'b0010;
    step();
    check("persist_gnt", 32'(gnt1), 32'h2);
    check("persist_stale", 32'(stale1), 32'h0);
    req1 = 4'b0000;
    step();
    step();
    req1 = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("consumed_gnt[%0d]", c), 32'(gnt1), 32'h0);
    end
    check("consumed_busy", 32'(busy1), 32'h0);
    req1 = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
